// File: rtl/conv_pkg.sv
// Shared types, default layer-0 coefficients and the ReLU/saturation helper.
// Latency: none (package only).
// Backpressure: not applicable.
package conv_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_ACC,
    C_WR
  } comp_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R0,
    R1,
    R2,
    R3,
    R_CMP,
    R_OUT,
    R_HOLD
  } rd_state_t;

  // Default layer-0 coefficients: ch0 taps all +1, ch1 taps all -1; ch0 bias 0, ch1 bias +5.
  localparam logic [161:0] L0_W = {{9{9'h1FF}}, {9{9'h001}}};
  localparam logic [17:0]  L0_B = {9'h005, 9'h000};

  // Clamp a signed sum to [0, 2^dw-1]; the caller slices the low dw bits.
  function automatic logic [31:0] relu_sat(input logic signed [31:0] s, input int unsigned dw);
    logic signed [32:0] s_w;
    logic signed [32:0] max_v;
    s_w   = 33'(s);
    max_v = (33'sd1 <<< dw) - 33'sd1;
    if (s_w <= 33'sd0) begin
      relu_sat = 32'd0;
    end else if (s_w > max_v) begin
      relu_sat = 32'(max_v);
    end else begin
      relu_sat = 32'(s_w);
    end
  endfunction

endpackage

// File: rtl/conv_bin_pool_layer_if.sv
// Handshake/data bundle between the window source, the conv layer and the next layer.
// Latency: none (wiring only).
// Backpressure: bsy_in from downstream, bsy_out/full towards the window source.
interface conv_bin_pool_layer_if #(
  parameter int DOUT_W = 32
);
  logic              strt;
  logic              din;
  logic              tx_done;
  logic              bsy_in;
  logic              bsy_out;
  logic              full;
  logic              rdy;
  logic              dout_vld;
  logic [DOUT_W-1:0] dout;
  logic              frame_done;

  modport master (
    output strt, din, tx_done, bsy_in,
    input  bsy_out, full, rdy, dout_vld, dout, frame_done
  );

  modport slave (
    input  strt, din, tx_done, bsy_in,
    output bsy_out, full, rdy, dout_vld, dout, frame_done
  );
endinterface

// File: rtl/conv_dp_ram.sv
// Feature-map buffer: one write port, one synchronous read port.
// Latency: read data valid one cycle after the address.
// Backpressure: none; accepts a write and a read every cycle.
module conv_dp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 676,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port; reads never target the address being written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_bin_pool_layer.sv
// Binary-window conv (NUM_CH channels, bias, ReLU+sat) into a buffer, then 2x2/stride-2 max-pool read-out.
// Latency: window written KTAPS+1 cycles after strt; pooled pixel strobed 5 cycles after R0.
// Backpressure: strt ignored while busy or full; bsy_in holds off starting a pooled read.
module conv_bin_pool_layer
  import conv_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int KTAPS  = 9,
  parameter int WW     = 9,
  parameter int AW     = 18,
  parameter int DW     = 16,
  parameter int OUT_W  = 26,
  parameter int OUT_H  = 26,
  parameter logic [NUM_CH*KTAPS*WW-1:0] WEIGHTS = conv_pkg::L0_W,
  parameter logic [NUM_CH*WW-1:0]       BIAS    = conv_pkg::L0_B
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_bin_pool_layer_if.slave bus
);

  localparam int NPIX  = OUT_W * OUT_H;
  localparam int NPOOL = (OUT_W / 2) * (OUT_H / 2);
  localparam int TW    = $clog2(KTAPS + 1);
  localparam int PW    = $clog2(NPIX + OUT_W + 3);
  localparam int RA    = $clog2(NPIX);
  localparam int CW    = $clog2(NPOOL + 1);
  localparam int CLW   = $clog2(OUT_W / 2 + 1);
  localparam int DTW   = NUM_CH * DW;

  if (AW < WW + $clog2(KTAPS) + 1) begin : g_chk_aw
    $error("AW too narrow for WW and KTAPS");
  end
  if (AW > 32) begin : g_chk_aw_max
    $error("AW above 32 not supported by relu_sat");
  end
  if ((OUT_W % 2) != 0) begin : g_chk_w
    $error("OUT_W must be even");
  end
  if ((OUT_H % 2) != 0) begin : g_chk_h
    $error("OUT_H must be even");
  end

  // ---------------- compute side ----------------
  comp_state_t          c_state_q, c_state_d;
  logic [TW-1:0]        tap_q, tap_d;
  logic [PW-1:0]        addr_wr_q, addr_wr_d;
  logic signed [AW-1:0] acc_q [NUM_CH];
  logic signed [AW-1:0] acc_d [NUM_CH];
  logic signed [AW-1:0] w_ext [NUM_CH];
  logic signed [AW-1:0] b_ext [NUM_CH];
  logic [DTW-1:0]       wdata;
  logic                 we;
  logic                 full;

  assign full = (addr_wr_q == PW'(NPIX));

  // Sign-extend the weight for the current tap and the bias of every channel.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_ext[c] = AW'($signed(WEIGHTS[(c*KTAPS + int'(tap_q))*WW +: WW]));
      b_ext[c] = AW'($signed(BIAS[c*WW +: WW]));
    end
  end

  // Compute FSM next state: accept a window, accumulate taps, write the activated result.
  always_comb begin
    c_state_d = c_state_q;
    tap_d     = tap_q;
    addr_wr_d = addr_wr_q;
    we        = 1'b0;
    wdata     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = acc_q[c];
      wdata[c*DW +: DW] = DW'(relu_sat(32'(acc_q[c] + b_ext[c]), DW));
    end
    case (c_state_q)
      C_IDLE: begin
        if (bus.strt && !full) begin
          c_state_d = C_ACC;
          tap_d     = '0;
          for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
        end
      end
      C_ACC: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.din) acc_d[c] = acc_q[c] + w_ext[c];
        end
        if (tap_q == TW'(KTAPS - 1)) begin
          tap_d     = '0;
          c_state_d = C_WR;
        end else begin
          tap_d = tap_q + TW'(1);
        end
      end
      C_WR: begin
        we        = 1'b1;
        addr_wr_d = addr_wr_q + PW'(1);
        c_state_d = C_IDLE;
      end
      default: c_state_d = C_IDLE;
    endcase
    if (bus.tx_done) begin
      c_state_d = C_IDLE;
      tap_d     = '0;
      addr_wr_d = '0;
      we        = 1'b0;
      for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
    end
  end

  // Compute-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state_q <= C_IDLE;
      tap_q     <= '0;
      addr_wr_q <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      c_state_q <= c_state_d;
      tap_q     <= tap_d;
      addr_wr_q <= addr_wr_d;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
    end
  end

  // ---------------- buffer ----------------
  logic [RA-1:0]  raddr;
  logic [DTW-1:0] rdata;

  conv_dp_ram #(
    .WIDTH  (DTW),
    .DEPTH  (NPIX),
    .ADDR_W (RA)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (RA'(addr_wr_q)),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // ---------------- read / pool side ----------------
  rd_state_t      r_state_q, r_state_d;
  logic [PW-1:0]  p_q, p_d;
  logic [CLW-1:0] col_q, col_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DTW-1:0] max_q, max_d, max_upd;
  logic [DTW-1:0] dout_q, dout_d;
  logic           vld_q, vld_d;
  logic           fd_q, fd_d;
  logic           rdy;

  // p is the bottom-right pixel of the next pool window; it is ready once written.
  assign rdy = (p_q < addr_wr_q);

  // Per-channel running maximum against the word returned by the RAM.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      max_upd[c*DW +: DW] = (rdata[c*DW +: DW] > max_q[c*DW +: DW]) ? rdata[c*DW +: DW]
                                                                    : max_q[c*DW +: DW];
    end
  end

  // Read FSM next state: fetch the four window pixels, reduce, emit, step to the next window.
  always_comb begin
    r_state_d = r_state_q;
    p_d       = p_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    dout_d    = dout_q;
    vld_d     = 1'b0;
    fd_d      = 1'b0;
    raddr     = RA'(p_q);
    case (r_state_q)
      R_IDLE: if (rdy && !bus.bsy_in) r_state_d = R0;
      R0: begin
        raddr     = RA'(p_q - PW'(OUT_W + 1));
        r_state_d = R1;
      end
      R1: begin
        raddr     = RA'(p_q - PW'(OUT_W));
        max_d     = rdata;
        r_state_d = R2;
      end
      R2: begin
        raddr     = RA'(p_q - PW'(1));
        max_d     = max_upd;
        r_state_d = R3;
      end
      R3: begin
        raddr     = RA'(p_q);
        max_d     = max_upd;
        r_state_d = R_CMP;
      end
      R_CMP: begin
        max_d     = max_upd;
        dout_d    = max_upd;
        vld_d     = 1'b1;
        fd_d      = (cnt_q == CW'(NPOOL - 1));
        r_state_d = R_OUT;
      end
      R_OUT: begin
        if (col_q == CLW'(OUT_W / 2 - 1)) begin
          p_d   = p_q + PW'(OUT_W + 2);
          col_d = '0;
        end else begin
          p_d   = p_q + PW'(2);
          col_d = col_q + CLW'(1);
        end
        cnt_d     = cnt_q + CW'(1);
        r_state_d = (cnt_q == CW'(NPOOL - 1)) ? R_HOLD : R_IDLE;
      end
      R_HOLD: r_state_d = R_HOLD;
      default: r_state_d = R_IDLE;
    endcase
    if (bus.tx_done) begin
      r_state_d = R_IDLE;
      p_d       = PW'(OUT_W + 1);
      col_d     = '0;
      cnt_d     = '0;
      max_d     = '0;
      dout_d    = '0;
      vld_d     = 1'b0;
      fd_d      = 1'b0;
    end
  end

  // Read-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      p_q       <= PW'(OUT_W + 1);
      col_q     <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      p_q       <= p_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.bsy_out    = (c_state_q != C_IDLE);
  assign bus.full       = full;
  assign bus.rdy        = rdy;
  assign bus.dout_vld   = vld_q;
  assign bus.dout       = dout_q;
  assign bus.frame_done = fd_q;

endmodule
